// File: rtl/hazard_ctrl_pkg.sv
// Shared processor constants: opcodes, ALU codes and mult/div FSM encoding.
// Imported by the hazard controller and its mult/div sequencer.
package hazard_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_md_op(
    input logic [4:0] op,
    input logic [4:0] alu
  );
    return (op == OP_RTYPE) &&
           ((alu == ALU_MULT) || (alu == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_md_seq.sv
// Mult/div sequencer: start pulses, busy counter with timeout,
// release and exception reporting.
module hazard_md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic md_op,
  input  logic is_div,
  input  logic md_rdy,
  input  logic md_exc,
  output logic ctrl_mult,
  output logic ctrl_div,
  output logic hold,
  output logic rel,
  output logic exc,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_e        state;
  md_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    hold      = 1'b0;
    rel       = 1'b0;
    exc       = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (md_op) begin
          ctrl_mult = !is_div;
          ctrl_div  = is_div;
          hold      = 1'b1;
          cnt_n     = '0;
          state_n   = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_rdy || (cnt == LAST)) begin
          rel     = 1'b1;
          exc     = md_rdy ? md_exc : 1'b1;
          cnt_n   = '0;
          state_n = MD_IDLE;
        end else begin
          hold = 1'b1;
          // saturate instead of wrapping
          if (cnt != '1)
            cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// mult/div sequencing merged by priority into PC/F/D/D/X/X/M controls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] op_d,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] op_x,
  input  logic [4:0] alu_x,
  input  logic [4:0] rd_x,
  input  logic       take_alt_x,
  input  logic       md_rdy,
  input  logic       md_exc,
  output logic       ctrl_mult,
  output logic       ctrl_div,
  output logic       pc_we,
  output logic       fd_we,
  output logic       dx_we,
  output logic       fd_flush,
  output logic       dx_bubble,
  output logic       xm_bubble,
  output logic       md_sel,
  output logic       md_exc_out,
  output logic       busy
);

  logic md_op;
  logic lw_x;
  logic load_use;
  logic seq_mult;
  logic seq_div;
  logic hold;
  logic rel;
  logic exc;
  logic seq_busy;
  logic unused_op_d;

  // hazard detection is conservative, so the D opcode is not needed
  assign unused_op_d = ^op_d;

  assign md_op    = is_md_op(op_x, alu_x);
  assign lw_x     = (op_x == OP_LW);
  assign load_use = lw_x && (rd_x != 5'd0) &&
                    ((rd_x == rs_d) || (rd_x == rt_d));

  hazard_md_seq #(
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_md_seq (
    .clock    (clock),
    .reset    (reset),
    .md_op    (md_op),
    .is_div   (alu_x == ALU_DIV),
    .md_rdy   (md_rdy),
    .md_exc   (md_exc),
    .ctrl_mult(seq_mult),
    .ctrl_div (seq_div),
    .hold     (hold),
    .rel      (rel),
    .exc      (exc),
    .busy     (seq_busy)
  );

  logic f_hold;
  logic f_rel;
  logic f_flush;
  logic f_lu;

  assign f_hold  = reset && hold;
  assign f_rel   = reset && rel;
  assign f_flush = reset && !hold && !rel && take_alt_x;
  assign f_lu    = reset && !hold && !rel && !take_alt_x && load_use;

  always_comb begin
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    pc_we      = 1'b1;
    fd_we      = 1'b1;
    dx_we      = 1'b1;
    fd_flush   = 1'b0;
    dx_bubble  = 1'b0;
    xm_bubble  = 1'b0;
    md_sel     = 1'b0;
    md_exc_out = 1'b0;
    unique case (1'b1)
      f_hold: begin
        ctrl_mult = seq_mult;
        ctrl_div  = seq_div;
        pc_we     = 1'b0;
        fd_we     = 1'b0;
        dx_we     = 1'b0;
        xm_bubble = 1'b1;
      end
      f_rel: begin
        md_sel     = 1'b1;
        md_exc_out = exc;
      end
      f_flush: begin
        fd_flush  = 1'b1;
        dx_bubble = 1'b1;
      end
      f_lu: begin
        pc_we     = 1'b0;
        fd_we     = 1'b0;
        dx_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = reset && seq_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for combinational hazards,
// hand sequences for mult/div start, release, timeout and reset abort.
module tb_hazard_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] op_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] op_x;
  logic [4:0] alu_x;
  logic [4:0] rd_x;
  logic       take_alt_x;
  logic       md_rdy;
  logic       md_exc;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       pc_we;
  logic       fd_we;
  logic       dx_we;
  logic       fd_flush;
  logic       dx_bubble;
  logic       xm_bubble;
  logic       md_sel;
  logic       md_exc_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .op_d      (op_d),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .op_x      (op_x),
    .alu_x     (alu_x),
    .rd_x      (rd_x),
    .take_alt_x(take_alt_x),
    .md_rdy    (md_rdy),
    .md_exc    (md_exc),
    .ctrl_mult (ctrl_mult),
    .ctrl_div  (ctrl_div),
    .pc_we     (pc_we),
    .fd_we     (fd_we),
    .dx_we     (dx_we),
    .fd_flush  (fd_flush),
    .dx_bubble (dx_bubble),
    .xm_bubble (xm_bubble),
    .md_sel    (md_sel),
    .md_exc_out(md_exc_out),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // order: mult div pc fd dx flush dxb xmb sel exc busy
  localparam logic [10:0] NORM = 11'b0_0_1_1_1_0_0_0_0_0_0;
  localparam logic [10:0] LU   = 11'b0_0_0_0_1_0_1_0_0_0_0;
  localparam logic [10:0] FL   = 11'b0_0_1_1_1_1_1_0_0_0_0;
  localparam logic [10:0] ST_M = 11'b1_0_0_0_0_0_0_1_0_0_0;
  localparam logic [10:0] ST_D = 11'b0_1_0_0_0_0_0_1_0_0_0;
  localparam logic [10:0] HOLD = 11'b0_0_0_0_0_0_0_1_0_0_1;
  localparam logic [10:0] REL0 = 11'b0_0_1_1_1_0_0_0_1_0_1;
  localparam logic [10:0] REL1 = 11'b0_0_1_1_1_0_0_0_1_1_1;

  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] LW  = 5'b01000;
  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  function automatic logic [10:0] outs();
    return {ctrl_mult, ctrl_div, pc_we, fd_we, dx_we, fd_flush,
            dx_bubble, xm_bubble, md_sel, md_exc_out, busy};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = outs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic set_x(input logic [4:0] op, input logic [4:0] alu,
                       input logic [4:0] rd);
    op_x  = op;
    alu_x = alu;
    rd_x  = rd;
  endtask

  task automatic step(input string name, input logic [10:0] exp);
    @(negedge clock);
    #1 check(name, exp);
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] op;
    logic [4:0] rd;
    logic       take;
    logic       rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{"add_no_hz", 5, 5, ADD, 5, 0, 0, NORM};
    vt[1] = '{"lu_rs", 5, 1, LW, 5, 0, 0, LU};
    vt[2] = '{"after_lu", 5, 1, ADD, 5, 0, 0, NORM};
    vt[3] = '{"lu_rt", 2, 5, LW, 5, 0, 0, LU};
    vt[4] = '{"lw_r0", 0, 0, LW, 0, 0, 0, NORM};
    vt[5] = '{"lw_nomatch", 6, 7, LW, 5, 0, 0, NORM};
    vt[6] = '{"flush_over_lu", 5, 5, LW, 5, 1, 0, FL};
    vt[7] = '{"flush_only", 3, 4, ADD, 9, 1, 0, FL};
    vt[8] = '{"rdy_idle", 3, 4, ADD, 9, 0, 1, NORM};
    vt[9] = '{"lu_r31", 1, 31, LW, 31, 0, 0, LU};

    reset = 1'b0;
    op_d = 5'b00001;
    rs_d = 5'd5;
    rt_d = 5'd5;
    set_x(ADD, MUL, 5'd5);
    take_alt_x = 1'b1;
    md_rdy = 1'b1;
    md_exc = 1'b1;
    #1 check("reset_forced", NORM);
    @(negedge clock);
    set_x(LW, 5'd0, 5'd5);
    take_alt_x = 1'b0;
    #1 check("reset_lu_forced", NORM);
    @(negedge clock);
    set_x(ADD, 5'd0, 5'd0);
    md_rdy = 1'b0;
    md_exc = 1'b0;
    reset = 1'b1;
    #1 check("after_reset", NORM);

    foreach (vt[i]) begin
      @(negedge clock);
      rs_d = vt[i].rs;
      rt_d = vt[i].rt;
      set_x(vt[i].op, 5'd0, vt[i].rd);
      take_alt_x = vt[i].take;
      md_rdy = vt[i].rdy;
      #1 check(vt[i].name, vt[i].exp);
    end

    // mult, ready 32 cycles after start
    @(negedge clock);
    take_alt_x = 1'b0;
    md_rdy = 1'b0;
    rs_d = 5'd1;
    rt_d = 5'd2;
    set_x(ADD, MUL, 5'd3);
    #1 check("mult_start", ST_M);
    for (int i = 1; i < 32; i++) step($sformatf("mult_hold%0d", i), HOLD);
    @(negedge clock);
    md_rdy = 1'b1;
    #1 check("mult_rel", REL0);
    @(negedge clock);
    md_rdy = 1'b0;
    set_x(ADD, 5'd0, 5'd3);
    #1 check("mult_idle", NORM);

    // div by zero
    @(negedge clock);
    set_x(ADD, DIV, 5'd4);
    #1 check("div_start", ST_D);
    for (int i = 1; i < 4; i++) step($sformatf("div_hold%0d", i), HOLD);
    @(negedge clock);
    md_rdy = 1'b1;
    md_exc = 1'b1;
    #1 check("div_rel_exc", REL1);
    @(negedge clock);
    md_rdy = 1'b0;
    md_exc = 1'b0;
    set_x(ADD, 5'd0, 5'd4);
    #1 check("div_idle", NORM);

    // timeout: release in 40th busy cycle
    @(negedge clock);
    set_x(ADD, MUL, 5'd6);
    #1 check("to_start", ST_M);
    for (int i = 1; i < 40; i++) step($sformatf("to_hold%0d", i), HOLD);
    step("to_rel", REL1);
    @(negedge clock);
    set_x(ADD, 5'd0, 5'd6);
    #1 check("to_idle", NORM);

    // back-to-back mult then div
    @(negedge clock);
    set_x(ADD, MUL, 5'd7);
    #1 check("b2b_mstart", ST_M);
    step("b2b_mhold", HOLD);
    @(negedge clock);
    md_rdy = 1'b1;
    #1 check("b2b_mrel", REL0);
    @(negedge clock);
    md_rdy = 1'b0;
    set_x(ADD, DIV, 5'd8);
    #1 check("b2b_dstart", ST_D);
    step("b2b_dhold", HOLD);

    // reset mid-busy aborts
    @(negedge clock);
    reset = 1'b0;
    #1 check("rst_busy_abort", NORM);
    @(negedge clock);
    md_rdy = 1'b1;
    md_exc = 1'b1;
    #1 check("rst_hold", NORM);
    @(negedge clock);
    reset = 1'b1;
    md_rdy = 1'b0;
    md_exc = 1'b0;
    set_x(ADD, 5'd0, 5'd8);
    #1 check("rst_release", NORM);
    step("post_rst1", NORM);
    step("post_rst2", NORM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
